// File: rtl/sprite_drawer.sv
// Sprite/background blitter: scans an SPR_W x SPR_H box, reads two ROMs,
// and emits one VGA pixel write per cycle through a two-stage pipeline.
module sprite_drawer #(
    parameter int         SPR_W  = 8,
    parameter int         SPR_H  = 8,
    parameter logic [8:0] TRANSP = 9'h1FF
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        drawBG,
    input  logic        drawChar,
    input  logic [8:0]  x,
    input  logic [7:0]  y,
    output logic [16:0] bg_addr,
    input  logic [8:0]  bg_data,
    output logic [5:0]  chr_addr,
    input  logic [8:0]  chr_data,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [8:0]  vga_colour,
    output logic        plot,
    output logic        doneBG,
    output logic        doneChar
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FLUSH,
        DONE,
        RELEASE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] col, col_n;
    logic [RW-1:0] row, row_n;
    logic          fl, fl_n;
    logic          job_bg, job_bg_n;
    logic [8:0]    xl, xl_n;
    logic [7:0]    yl, yl_n;

    logic [9:0]    px, py;
    logic          onscr;
    logic          last_col, last_pix;

    logic          v1;
    logic [8:0]    px1;
    logic [7:0]    py1;

    // 10-bit screen coordinates so the box never wraps past the screen edge
    assign px       = 10'(xl) + 10'(col);
    assign py       = 10'(yl) + 10'(row);
    assign onscr    = (px < 10'd320) && (py < 10'd240);
    assign bg_addr  = 17'(py) * 17'd320 + 17'(px);
    assign chr_addr = 6'(int'(row) * SPR_W + int'(col));
    assign last_col = (int'(col) == SPR_W - 1);
    assign last_pix = last_col && (int'(row) == SPR_H - 1);

    always_comb begin
        state_n  = state;
        col_n    = col;
        row_n    = row;
        fl_n     = fl;
        job_bg_n = job_bg;
        xl_n     = xl;
        yl_n     = yl;
        doneBG   = 1'b0;
        doneChar = 1'b0;
        unique case (state)
            IDLE: begin
                if (drawBG || drawChar) begin
                    xl_n     = x;
                    yl_n     = y;
                    job_bg_n = drawBG;
                    col_n    = '0;
                    row_n    = '0;
                    state_n  = SCAN;
                end
            end
            SCAN: begin
                if (last_pix) begin
                    col_n   = '0;
                    row_n   = '0;
                    fl_n    = 1'b0;
                    state_n = FLUSH;
                end else if (last_col) begin
                    col_n = '0;
                    row_n = row + 1'b1;
                end else begin
                    col_n = col + 1'b1;
                end
            end
            FLUSH: begin
                fl_n = 1'b1;
                if (fl) state_n = DONE;
            end
            DONE: begin
                doneBG   = job_bg;
                doneChar = !job_bg;
                state_n  = RELEASE;
            end
            RELEASE: begin
                if (job_bg ? !drawBG : !drawChar) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= IDLE;
            col    <= '0;
            row    <= '0;
            fl     <= 1'b0;
            job_bg <= 1'b0;
            xl     <= '0;
            yl     <= '0;
        end else begin
            state  <= state_n;
            col    <= col_n;
            row    <= row_n;
            fl     <= fl_n;
            job_bg <= job_bg_n;
            xl     <= xl_n;
            yl     <= yl_n;
        end
    end

    // Stage 1 waits alongside the ROM read; stage 2 picks the colour
    always_ff @(posedge clock) begin
        if (!resetn) begin
            v1         <= 1'b0;
            px1        <= '0;
            py1        <= '0;
            plot       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            v1  <= (state == SCAN) && onscr;
            px1 <= px[8:0];
            py1 <= py[7:0];
            if (v1 && (job_bg || chr_data != TRANSP)) begin
                plot       <= 1'b1;
                vga_x      <= px1;
                vga_y      <= py1;
                vga_colour <= job_bg ? bg_data : chr_data;
            end else begin
                plot <= 1'b0;
            end
        end
    end

endmodule
